// File: rtl/pressure_monitor.sv
// ---------------------------------------------------------------------------
// pressure_monitor
//
// Clocked pressure window monitor. A pressure sample is taken on each cycle
// with pValid=1 and classified against the inclusive in-range window
// [LOW_TH, HIGH_TH]. A warning is raised only after PERSIST consecutive
// out-of-range samples and cleared only after PERSIST consecutive in-range
// samples (symmetric hysteresis). Cycles without pValid are transparent.
// Each entry into warning sets a sticky alarm and bumps a saturating event
// counter.
//
// Ports:
//   clk          in   clock, all state changes on the rising edge
//   rst          in   asynchronous active-high reset
//   pValid       in   pData carries a sample this cycle
//   pData        in   unsigned pressure sample, DATA_W bits
//   pAck         in   clears the sticky alarm (a new alarm set wins)
//   pWarning     out  qualified warning level
//   pLow         out  latest out-of-range sample was below LOW_TH
//   pHigh        out  latest out-of-range sample was above HIGH_TH
//   pAlarm       out  sticky alarm, set on each fresh entry to warning
//   pAlarmCount  out  saturating count of warning entries, CNT_W bits
//   pState       out  debug FSM state (0 NORMAL, 1 PEND_WARN, 2 WARNING,
//                     3 PEND_CLEAR)
// ---------------------------------------------------------------------------
module pressure_monitor #(
    parameter int DATA_W  = 5,
    parameter int LOW_TH  = 8,
    parameter int HIGH_TH = 22,
    parameter int PERSIST = 4,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pValid,
    input  logic [DATA_W-1:0] pData,
    input  logic              pAck,
    output logic              pWarning,
    output logic              pLow,
    output logic              pHigh,
    output logic              pAlarm,
    output logic [CNT_W-1:0]  pAlarmCount,
    output logic [1:0]        pState
);

    // Elaboration-time sanity check of the parameter set.
    if (!((LOW_TH >= 0) && (LOW_TH <= HIGH_TH) &&
          (longint'(HIGH_TH) < (longint'(1) << DATA_W)) && (PERSIST >= 1))) begin : g_bad_params
        $error("pressure_monitor: illegal parameters (need 0 <= LOW_TH <= HIGH_TH <= 2**DATA_W-1, PERSIST >= 1)");
    end

    localparam int RUN_W = $clog2(PERSIST + 1);

    // Run counter value that, once incremented, completes a persistence run.
    localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(PERSIST - 1);
    localparam logic [DATA_W-1:0] LOW_V    = DATA_W'(LOW_TH);
    localparam logic [DATA_W-1:0] HIGH_V   = DATA_W'(HIGH_TH);

    typedef enum logic [1:0] {
        NORMAL     = 2'd0,
        PEND_WARN  = 2'd1,
        WARNING    = 2'd2,
        PEND_CLEAR = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [RUN_W-1:0]   cnt_reg, cnt_next;
    logic               warning_reg, warning_next;
    logic               low_reg, low_next;
    logic               high_reg, high_next;
    logic               alarm_reg, alarm_next;
    logic [CNT_W-1:0]   count_reg, count_next;

    logic               below;
    logic               above;
    logic               out_sample;
    logic               alarm_set;

    assign below      = (pData < LOW_V);
    assign above      = (pData > HIGH_V);
    assign out_sample = below | above;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= NORMAL;
            cnt_reg     <= '0;
            warning_reg <= 1'b0;
            low_reg     <= 1'b0;
            high_reg    <= 1'b0;
            alarm_reg   <= 1'b0;
            count_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            warning_reg <= warning_next;
            low_reg     <= low_next;
            high_reg    <= high_next;
            alarm_reg   <= alarm_next;
            count_reg   <= count_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        low_next   = low_reg;
        high_next  = high_reg;
        alarm_set  = 1'b0;

        if (pValid) begin
            // Direction flags track the most recent out-of-range sample.
            if (out_sample) begin
                low_next  = below;
                high_next = above;
            end

            unique case (state_reg)
                NORMAL: begin
                    if (out_sample) begin
                        if (PERSIST == 1) begin
                            state_next = WARNING;
                            cnt_next   = '0;
                            alarm_set  = 1'b1;
                        end else begin
                            state_next = PEND_WARN;
                            cnt_next   = RUN_W'(1);
                        end
                    end
                end
                PEND_WARN: begin
                    if (out_sample) begin
                        if (cnt_reg == RUN_LAST) begin
                            state_next = WARNING;
                            cnt_next   = '0;
                            alarm_set  = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + RUN_W'(1);
                        end
                    end else begin
                        state_next = NORMAL;
                        cnt_next   = '0;
                    end
                end
                WARNING: begin
                    if (!out_sample) begin
                        if (PERSIST == 1) begin
                            state_next = NORMAL;
                            cnt_next   = '0;
                        end else begin
                            state_next = PEND_CLEAR;
                            cnt_next   = RUN_W'(1);
                        end
                    end
                end
                PEND_CLEAR: begin
                    if (!out_sample) begin
                        if (cnt_reg == RUN_LAST) begin
                            state_next = NORMAL;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + RUN_W'(1);
                        end
                    end else begin
                        // Falling back into warning is not a fresh entry.
                        state_next = WARNING;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = NORMAL;
                    cnt_next   = '0;
                end
            endcase

            // Returning to NORMAL forgets the last direction.
            if ((state_next == NORMAL) && (state_reg != NORMAL)) begin
                low_next  = 1'b0;
                high_next = 1'b0;
            end
        end

        warning_next = (state_next == WARNING) || (state_next == PEND_CLEAR);

        // A fresh set overrides an acknowledge on the same edge.
        alarm_next = alarm_set | (alarm_reg & ~pAck);

        count_next = count_reg;
        if (alarm_set && (count_reg != {CNT_W{1'b1}})) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    assign pWarning    = warning_reg;
    assign pLow        = low_reg;
    assign pHigh       = high_reg;
    assign pAlarm      = alarm_reg;
    assign pAlarmCount = count_reg;
    assign pState      = state_reg;

endmodule
